// File: rtl/midori_affine_pkg.sv
// midori_affine_pkg: mode encoding and nibble helpers shared by the affine pipeline
package midori_affine_pkg;
  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_IN     = 2'd1,
    MODE_OUT    = 2'd2,
    MODE_MID    = 2'd3
  } mode_e;
  // The constant inversion only lands on share 0 so the XOR of shares stays the unmasked image.
  function automatic logic [3:0] nib_map(input logic [3:0] x, input logic [1:0] mode, input logic is_share0);
    return mode == MODE_IN  ? {x[0] ^ x[2], x[3], x[0], x[1]} :
           mode == MODE_OUT ? {x[1] ^ is_share0, x[2] ^ x[3], x[0], x[2]} :
           mode == MODE_MID ? {x[2] ^ x[0] ^ is_share0, x[0], x[1], x[1] ^ x[3]} : x;
  endfunction
  function automatic int nib_idx(input int s, input int n, input int n_nibbles);
    return (s * n_nibbles + n) * 4;
  endfunction
endpackage

// File: rtl/midori_affine_nib.sv
// midori_affine_nib: combinational affine map of a single nibble of one share
module midori_affine_nib
  import midori_affine_pkg::*;
#(
  parameter bit IS_SHARE0 = 1'b0
) (
  input  logic [3:0] x,
  input  logic [1:0] mode,
  output logic [3:0] y
);
  assign y = nib_map(x, mode, IS_SHARE0);
endmodule

// File: rtl/midori_affine_pipe.sv
// midori_affine_pipe: registered masked Midori affine layer; MIDORI_AFFINE_REFRESH_EN adds a ring refresh
module midori_affine_pipe
  import midori_affine_pkg::*;
#(
  parameter int N_SHARES = 3,
  parameter int N_NIBBLES = 1,
  localparam int W = N_SHARES * N_NIBBLES * 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_mode,
  input  logic [W-1:0] in_data,
`ifdef MIDORI_AFFINE_REFRESH_EN
  input  logic [W-1:0] in_rnd,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_mode,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mapped;
  logic [W-1:0] next_data;
  logic         accept;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  for (genvar s = 0; s < N_SHARES; s++) begin : g_s
    for (genvar n = 0; n < N_NIBBLES; n++) begin : g_n
      midori_affine_nib #(.IS_SHARE0(s == 0)) u_nib (
        .x(in_data[nib_idx(s, n, N_NIBBLES) +: 4]),
        .mode(in_mode),
        .y(mapped[nib_idx(s, n, N_NIBBLES) +: 4])
      );
    end
  end
`ifdef MIDORI_AFFINE_REFRESH_EN
  localparam int SW = W / N_SHARES;
  for (genvar s = 0; s < N_SHARES; s++) begin : g_r
    assign next_data[s*SW +: SW] = mapped[s*SW +: SW] ^ in_rnd[s*SW +: SW]
                                 ^ in_rnd[((s + 1) % N_SHARES)*SW +: SW];
  end
`else
  assign next_data = mapped;
`endif
  // Single-entry output register; on drain without accept only valid drops, data stays stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= next_data;
      out_mode  <= in_mode;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_midori_affine_pipe.sv
// tb_midori_affine_pipe: directed vectors, back-pressure, async reset and streaming checks
module tb_midori_affine_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic        a_valid, a_in_ready, a_out_valid, a_ready;
  logic [1:0]  a_mode, a_out_mode;
  logic [11:0] a_data, a_out_data;
  logic        b_valid, b_in_ready, b_out_valid, b_ready;
  logic [1:0]  b_mode, b_out_mode;
  logic [47:0] b_data, b_out_data;
`ifdef MIDORI_AFFINE_REFRESH_EN
  logic [11:0] a_rnd;
  logic [47:0] b_rnd;
  logic [47:0] delta;
`endif
  midori_affine_pipe #(.N_SHARES(3), .N_NIBBLES(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_in_ready), .in_mode(a_mode), .in_data(a_data),
`ifdef MIDORI_AFFINE_REFRESH_EN
    .in_rnd(a_rnd),
`endif
    .out_valid(a_out_valid), .out_ready(a_ready), .out_mode(a_out_mode), .out_data(a_out_data)
  );
  midori_affine_pipe #(.N_SHARES(3), .N_NIBBLES(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_in_ready), .in_mode(b_mode), .in_data(b_data),
`ifdef MIDORI_AFFINE_REFRESH_EN
    .in_rnd(b_rnd),
`endif
    .out_valid(b_out_valid), .out_ready(b_ready), .out_mode(b_out_mode), .out_data(b_out_data)
  );
  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] ref_map(input logic [3:0] x, input logic [1:0] m, input bit s0);
    logic [3:0] y;
    y = x;
    case (m)
      2'd1: begin y[3] = x[0] ^ x[2]; y[2] = x[3]; y[1] = x[0]; y[0] = x[1]; end
      2'd2: begin y[3] = s0 ? ~x[1] : x[1]; y[2] = x[2] ^ x[3]; y[1] = x[0]; y[0] = x[2]; end
      2'd3: begin y[3] = s0 ? ~(x[2] ^ x[0]) : (x[2] ^ x[0]); y[2] = x[0]; y[1] = x[1]; y[0] = x[1] ^ x[3]; end
      default: y = x;
    endcase
    return y;
  endfunction
  function automatic logic [47:0] ref_b(input logic [47:0] d, input logic [1:0] m);
    logic [47:0] r;
    r = '0;
    for (int s = 0; s < 3; s++)
      for (int n = 0; n < 4; n++)
        r[(s*4+n)*4 +: 4] = ref_map(d[(s*4+n)*4 +: 4], m, s == 0);
    return r;
  endfunction
  function automatic logic [15:0] xsh(input logic [47:0] d);
    return d[15:0] ^ d[31:16] ^ d[47:32];
  endfunction
  typedef struct {
    logic [1:0]  mode;
    logic [11:0] data;
    logic [11:0] exp;
  } vec_t;
  typedef struct {
    logic [1:0]  mode;
    logic [47:0] raw;
    logic [47:0] exp;
    logic [15:0] xu;
  } item_t;
  vec_t vec[10];
  item_t q[$];
  item_t it;
  logic [15:0] xin;
  initial begin
    vec[0] = '{2'd1, 12'h555, 12'h222};
    vec[1] = '{2'd2, 12'h555, 12'h77F};
    vec[2] = '{2'd3, 12'h000, 12'h008};
    vec[3] = '{2'd0, 12'h9A3, 12'h9A3};
    vec[4] = '{2'd1, 12'hF0F, 12'h707};
    vec[5] = '{2'd2, 12'h000, 12'h008};
    vec[6] = '{2'd3, 12'hFFF, 12'h66E};
    vec[7] = '{2'd2, 12'h123, 12'h282};
    vec[8] = '{2'd3, 12'hA5C, 12'h241};
    vec[9] = '{2'd1, 12'h8C1, 12'h4CA};
    rst = 1'b1;
    a_valid = 0; a_ready = 1; a_mode = 0; a_data = '0;
    b_valid = 0; b_ready = 1; b_mode = 0; b_data = '0;
`ifdef MIDORI_AFFINE_REFRESH_EN
    a_rnd = '0; b_rnd = '0;
`endif
    #2;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_mode", a_out_mode, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("idle_in_ready", a_in_ready, 1);
    chk("idle_b_in_ready", b_in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      a_valid = 1; a_mode = vec[i].mode; a_data = vec[i].data;
      step();
      chk($sformatf("vec%0d_valid", i), a_out_valid, 1);
      chk($sformatf("vec%0d_data", i), a_out_data, vec[i].exp);
      chk($sformatf("vec%0d_mode", i), a_out_mode, vec[i].mode);
      chk($sformatf("vec%0d_in_ready", i), a_in_ready, 1);
    end
    a_valid = 0;
    step();
    chk("drain_valid", a_out_valid, 0);
    chk("drain_stale_data", a_out_data, 12'h4CA);
    chk("drain_stale_mode", a_out_mode, 1);
    a_ready = 0; a_valid = 1; a_mode = 1; a_data = 12'h555;
    step();
    chk("bp_first_valid", a_out_valid, 1);
    chk("bp_first_data", a_out_data, 12'h222);
    a_mode = 2;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", a_in_ready, 0);
      step();
      chk("bp_hold_data", a_out_data, 12'h222);
      chk("bp_hold_mode", a_out_mode, 1);
      chk("bp_hold_valid", a_out_valid, 1);
    end
    a_ready = 1;
    #1;
    chk("bp_release_in_ready", a_in_ready, 1);
    step();
    chk("bp_swap_valid", a_out_valid, 1);
    chk("bp_swap_data", a_out_data, 12'h77F);
    chk("bp_swap_mode", a_out_mode, 2);
    a_valid = 0;
    step();
    chk("bp_empty_valid", a_out_valid, 0);
    a_ready = 0; a_valid = 1; a_mode = 3; a_data = 12'h000;
    step();
    chk("ar_pre_valid", a_out_valid, 1);
    chk("ar_pre_data", a_out_data, 12'h008);
    #2 rst = 1'b1;
    #1;
    chk("ar_async_valid", a_out_valid, 0);
    chk("ar_async_data", a_out_data, 0);
    chk("ar_async_mode", a_out_mode, 0);
    a_valid = 0; a_ready = 1;
    step();
    rst = 1'b0;
    #1;
    chk("ar_after_in_ready", a_in_ready, 1);
    for (int i = 0; i < 300; i++) begin
      step();
      b_valid = (i < 290) ? 1'($urandom_range(0, 1)) : 1'b0;
      b_ready = (i < 290) ? ($urandom_range(0, 3) != 0) : 1'b1;
      b_mode = 2'($urandom_range(0, 3));
      b_data = {16'($urandom), $urandom};
`ifdef MIDORI_AFFINE_REFRESH_EN
      b_rnd = {16'($urandom), $urandom};
`endif
      @(negedge clk);
      if (b_out_valid && b_ready) begin
        chk("stream_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          it = q.pop_front();
          chk("stream_data", b_out_data, it.exp);
          chk("stream_mode", b_out_mode, it.mode);
          chk("stream_xor", xsh(b_out_data), it.xu);
`ifdef MIDORI_AFFINE_REFRESH_EN
          if (it.exp != it.raw) chk("stream_refreshed", b_out_data != it.raw, 1);
`endif
        end
      end
      if (b_valid && b_in_ready) begin
        it.mode = b_mode;
        it.raw = ref_b(b_data, b_mode);
        it.exp = it.raw;
`ifdef MIDORI_AFFINE_REFRESH_EN
        for (int s = 0; s < 3; s++)
          delta[s*16 +: 16] = b_rnd[s*16 +: 16] ^ b_rnd[((s + 1) % 3)*16 +: 16];
        it.exp = it.raw ^ delta;
`endif
        xin = xsh(b_data);
        for (int n = 0; n < 4; n++) it.xu[n*4 +: 4] = ref_map(xin[n*4 +: 4], b_mode, 1'b1);
        q.push_back(it);
      end
    end
    chk("stream_drained", q.size(), 0);
    step();
    b_ready = 0; b_valid = 1;
    step();
    chk("ms_pre_valid", b_out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ms_async_valid", b_out_valid, 0);
    chk("ms_async_data", b_out_data, 0);
    b_valid = 0;
    step();
    rst = 1'b0;
    #1;
    chk("ms_after_in_ready", b_in_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
